// File: rtl/white_ballance_stat.sv
// Gray-world statistics: zero-latency AXI4-Stream passthrough plus per-frame R/G/B sums latched at end of frame.
// Optional WB_STAT_SAT_EXCL_EN: pixels with any saturated channel are left out of the sums and pixel count.
module white_ballance_stat #(
  parameter int PX_WIDTH      = 10,
  parameter int TDATA_WIDTH   = 32,
  parameter int TDATA_WIDTH_B = 4,
  parameter int TID_WIDTH     = 4,
  parameter int TDEST_WIDTH   = 4,
  parameter int FRAME_RES_X   = 1920,
  parameter int FRAME_RES_Y   = 1080,
  parameter int SUM_WIDTH     = PX_WIDTH + $clog2(FRAME_RES_X * FRAME_RES_Y),
  parameter int CNT_WIDTH     = $clog2(FRAME_RES_X * FRAME_RES_Y + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [TDATA_WIDTH-1:0]   video_i_tdata,
  input  logic [TDATA_WIDTH_B-1:0] video_i_tstrb,
  input  logic [TDATA_WIDTH_B-1:0] video_i_tkeep,
  input  logic                     video_i_tlast,
  input  logic                     video_i_tuser,
  input  logic [TID_WIDTH-1:0]     video_i_tid,
  input  logic [TDEST_WIDTH-1:0]   video_i_tdest,
  input  logic                     video_i_tvalid,
  output logic                     video_i_tready,
  output logic [TDATA_WIDTH-1:0]   video_o_tdata,
  output logic [TDATA_WIDTH_B-1:0] video_o_tstrb,
  output logic [TDATA_WIDTH_B-1:0] video_o_tkeep,
  output logic                     video_o_tlast,
  output logic                     video_o_tuser,
  output logic [TID_WIDTH-1:0]     video_o_tid,
  output logic [TDEST_WIDTH-1:0]   video_o_tdest,
  output logic                     video_o_tvalid,
  input  logic                     video_o_tready,
  output logic [SUM_WIDTH-1:0]     stat_r_sum_o,
  output logic [SUM_WIDTH-1:0]     stat_g_sum_o,
  output logic [SUM_WIDTH-1:0]     stat_b_sum_o,
  output logic [CNT_WIDTH-1:0]     stat_px_cnt_o,
  output logic                     stat_valid_o,
  output logic                     stat_frame_err_o
);

  localparam int XW = $clog2(FRAME_RES_X + 2);
  localparam int YW = $clog2(FRAME_RES_Y + 1);

  typedef enum logic {IDLE, ACC} state_t;

  state_t                 state;
  logic [SUM_WIDTH-1:0]   r_acc, g_acc, b_acc;
  logic [CNT_WIDTH-1:0]   px_acc;
  logic [XW-1:0]          x_cnt;
  logic [YW-1:0]          y_cnt;

  assign video_o_tdata  = video_i_tdata;
  assign video_o_tstrb  = video_i_tstrb;
  assign video_o_tkeep  = video_i_tkeep;
  assign video_o_tlast  = video_i_tlast;
  assign video_o_tuser  = video_i_tuser;
  assign video_o_tid    = video_i_tid;
  assign video_o_tdest  = video_i_tdest;
  assign video_o_tvalid = video_i_tvalid;
  assign video_i_tready = video_o_tready;

  logic [PX_WIDTH-1:0] r_ch, g_ch, b_ch;
  logic                take;
  assign b_ch = video_i_tdata[PX_WIDTH-1:0];
  assign g_ch = video_i_tdata[2*PX_WIDTH-1:PX_WIDTH];
  assign r_ch = video_i_tdata[3*PX_WIDTH-1:2*PX_WIDTH];

`ifdef WB_STAT_SAT_EXCL_EN
  localparam logic [PX_WIDTH-1:0] PX_MAX = '1;
  assign take = !((r_ch == PX_MAX) || (g_ch == PX_MAX) || (b_ch == PX_MAX));
`else
  assign take = 1'b1;
`endif

  logic                 beat, sof, active, line_ok, eof;
  logic                 err_sof, err_eol, err_ovr;
  logic [SUM_WIDTH-1:0] r_nxt, g_nxt, b_nxt;
  logic [CNT_WIDTH-1:0] px_nxt;
  logic [XW-1:0]        x_nxt;
  logic [YW-1:0]        y_base, y_nxt;

  // A SOF beat restarts from zero, so every "next" value is built on a base that SOF clears.
  always_comb begin
    beat    = video_i_tvalid && video_o_tready;
    sof     = beat && video_i_tuser;
    active  = sof || (beat && (state == ACC));
    r_nxt   = (sof ? '0 : r_acc) + (take ? SUM_WIDTH'(r_ch) : '0);
    g_nxt   = (sof ? '0 : g_acc) + (take ? SUM_WIDTH'(g_ch) : '0);
    b_nxt   = (sof ? '0 : b_acc) + (take ? SUM_WIDTH'(b_ch) : '0);
    px_nxt  = (sof ? '0 : px_acc) + CNT_WIDTH'(take);
    x_nxt   = (sof ? '0 : x_cnt) + XW'(1);
    y_base  = sof ? '0 : y_cnt;
    y_nxt   = y_base + YW'(1);
    line_ok = (x_nxt == XW'(FRAME_RES_X));
    err_sof = sof && (state == ACC);
    err_eol = active && video_i_tlast && !line_ok;
    err_ovr = beat && (state == ACC) && !video_i_tuser && !video_i_tlast
              && (x_cnt == XW'(FRAME_RES_X));
    eof     = active && video_i_tlast && line_ok && (y_nxt == YW'(FRAME_RES_Y));
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state            <= IDLE;
      r_acc            <= '0;
      g_acc            <= '0;
      b_acc            <= '0;
      px_acc           <= '0;
      x_cnt            <= '0;
      y_cnt            <= '0;
      stat_r_sum_o     <= '0;
      stat_g_sum_o     <= '0;
      stat_b_sum_o     <= '0;
      stat_px_cnt_o    <= '0;
      stat_valid_o     <= 1'b0;
      stat_frame_err_o <= 1'b0;
    end else begin
      stat_valid_o     <= 1'b0;
      stat_frame_err_o <= 1'b0;
      if (active) begin
        if (err_sof || err_eol || err_ovr)
          stat_frame_err_o <= 1'b1;
        if (err_eol || err_ovr) begin
          state <= IDLE;
        end else if (eof) begin
          stat_r_sum_o  <= r_nxt;
          stat_g_sum_o  <= g_nxt;
          stat_b_sum_o  <= b_nxt;
          stat_px_cnt_o <= px_nxt;
          stat_valid_o  <= 1'b1;
          state         <= IDLE;
        end else begin
          state  <= ACC;
          r_acc  <= r_nxt;
          g_acc  <= g_nxt;
          b_acc  <= b_nxt;
          px_acc <= px_nxt;
          x_cnt  <= video_i_tlast ? '0 : x_nxt;
          y_cnt  <= video_i_tlast ? y_nxt : y_base;
        end
      end
    end
  end

endmodule

// File: tb/tb_white_ballance_stat.sv
// Bench for white_ballance_stat on a 4x2 frame: table-driven frames, corner sequences, random stream vs queue model.
`timescale 1ns/1ps
module tb_white_ballance_stat;
  localparam int PXW = 10, TDW = 32, TBW = 4, IDW = 4, DSW = 4, X = 4, Y = 2;
  localparam int SW = PXW + $clog2(X * Y);
  localparam int CW = $clog2(X * Y + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [TDW-1:0] i_tdata = '0;
  logic [TBW-1:0] i_tstrb = '0, i_tkeep = '0;
  logic           i_tlast = 1'b0, i_tuser = 1'b0, i_tvalid = 1'b0, i_tready;
  logic [IDW-1:0] i_tid = '0;
  logic [DSW-1:0] i_tdest = '0;
  logic [TDW-1:0] o_tdata;
  logic [TBW-1:0] o_tstrb, o_tkeep;
  logic           o_tlast, o_tuser, o_tvalid;
  logic           o_tready = 1'b0;
  logic [IDW-1:0] o_tid;
  logic [DSW-1:0] o_tdest;
  logic [SW-1:0]  st_r, st_g, st_b;
  logic [CW-1:0]  st_cnt;
  logic           st_valid, st_err;

  white_ballance_stat #(
    .PX_WIDTH(PXW), .TDATA_WIDTH(TDW), .TDATA_WIDTH_B(TBW), .TID_WIDTH(IDW),
    .TDEST_WIDTH(DSW), .FRAME_RES_X(X), .FRAME_RES_Y(Y)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .video_i_tdata(i_tdata), .video_i_tstrb(i_tstrb), .video_i_tkeep(i_tkeep),
    .video_i_tlast(i_tlast), .video_i_tuser(i_tuser), .video_i_tid(i_tid),
    .video_i_tdest(i_tdest), .video_i_tvalid(i_tvalid), .video_i_tready(i_tready),
    .video_o_tdata(o_tdata), .video_o_tstrb(o_tstrb), .video_o_tkeep(o_tkeep),
    .video_o_tlast(o_tlast), .video_o_tuser(o_tuser), .video_o_tid(o_tid),
    .video_o_tdest(o_tdest), .video_o_tvalid(o_tvalid), .video_o_tready(o_tready),
    .stat_r_sum_o(st_r), .stat_g_sum_o(st_g), .stat_b_sum_o(st_b),
    .stat_px_cnt_o(st_cnt), .stat_valid_o(st_valid), .stat_frame_err_o(st_err)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int n_valid = 0, n_err = 0;

  // Reference model: keeps the pixels of the frame in progress and sums them when the frame completes.
  bit     in_frame = 1'b0;
  int     fr_r[$], fr_g[$], fr_b[$];
  int     line_len = 0, lines = 0;
  longint m_r = 0, m_g = 0, m_b = 0, m_c = 0;
  bit     m_valid = 1'b0, m_err = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic bit excluded(input int r, input int g, input int b);
`ifdef WB_STAT_SAT_EXCL_EN
    return (r == 1023) || (g == 1023) || (b == 1023);
`else
    return (r < 0) && (g < 0) && (b < 0);
`endif
  endfunction

  task automatic model_reset();
    in_frame = 1'b0; fr_r.delete(); fr_g.delete(); fr_b.delete();
    line_len = 0; lines = 0;
    m_r = 0; m_g = 0; m_b = 0; m_c = 0; m_valid = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_beat(input int r, input int g, input int b, input bit sof, input bit eol);
    if (sof) begin
      if (in_frame) m_err = 1'b1;
      in_frame = 1'b1; fr_r.delete(); fr_g.delete(); fr_b.delete();
      line_len = 0; lines = 0;
    end
    if (!in_frame) return;
    if (!eol && line_len == X) begin
      m_err = 1'b1; in_frame = 1'b0; return;
    end
    fr_r.push_back(r); fr_g.push_back(g); fr_b.push_back(b);
    line_len++;
    if (eol) begin
      if (line_len != X) begin
        m_err = 1'b1; in_frame = 1'b0; return;
      end
      line_len = 0; lines++;
      if (lines == Y) begin
        m_r = 0; m_g = 0; m_b = 0; m_c = 0;
        foreach (fr_r[k]) begin
          if (!excluded(fr_r[k], fr_g[k], fr_b[k])) begin
            m_r += fr_r[k]; m_g += fr_g[k]; m_b += fr_b[k]; m_c++;
          end
        end
        m_valid = 1'b1; in_frame = 1'b0;
      end
    end
  endtask

  // Checks outputs produced by the previous edge, then feeds the beat about to be accepted.
  always @(negedge clk) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      check("passthrough", {o_tdata, o_tstrb, o_tkeep, o_tlast, o_tuser, o_tid, o_tdest, o_tvalid},
                           {i_tdata, i_tstrb, i_tkeep, i_tlast, i_tuser, i_tid, i_tdest, i_tvalid});
      check("tready", i_tready, o_tready);
      check("model_r", st_r, m_r);
      check("model_g", st_g, m_g);
      check("model_b", st_b, m_b);
      check("model_cnt", st_cnt, m_c);
      check("model_valid", st_valid, m_valid);
      check("model_err", st_err, m_err);
      if (st_valid) n_valid++;
      if (st_err) n_err++;
      m_valid = 1'b0; m_err = 1'b0;
      if (i_tvalid && o_tready)
        model_beat(int'(i_tdata[29:20]), int'(i_tdata[19:10]), int'(i_tdata[9:0]), i_tuser, i_tlast);
    end
  end

  task automatic idle(input int n);
    i_tvalid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [9:0] r, input logic [9:0] g, input logic [9:0] b,
                           input bit sof, input bit eol, input int gap, input int bp);
    int  tries;
    bit  done;
    tries = 0; done = 1'b0;
    while (gap > 0 && $urandom_range(99) < gap) begin
      i_tvalid = 1'b0; o_tready = 1'($urandom_range(1));
      @(posedge clk); #1;
    end
    i_tdata = {2'($urandom_range(3)), r, g, b};
    i_tstrb = 4'($urandom); i_tkeep = 4'($urandom);
    i_tid = 4'($urandom); i_tdest = 4'($urandom);
    i_tuser = sof; i_tlast = eol; i_tvalid = 1'b1;
    while (!done) begin
      o_tready = (bp == 0) || ($urandom_range(99) >= bp);
      done = o_tready;
      @(posedge clk); #1;
      tries++;
      if (!done && tries > 200) begin
        checks++; failures++;
        $display("FAIL handshake_timeout actual=%0d cycles required=acceptance", tries);
        done = 1'b1;
      end
    end
    i_tvalid = 1'b0;
  endtask

  typedef struct {
    int r, g, b;
    int short_at;   // 1-based beat of line 0 carrying an early tlast; 0 = well-formed
    int sat_idx;    // pixel whose R is forced to 1023; -1 = none
    int exp_valid, exp_err;
    int er, eg, eb, ec;
  } vec_t;

  task automatic run_vec(input int id, input vec_t v, input int gap, input int bp);
    n_valid = 0; n_err = 0;
    for (int i = 0; i < X * Y; i++) begin
      bit eol;
      logic [9:0] r;
      eol = ((i % X) == X - 1) || (i + 1 == v.short_at);
      r = (i == v.sat_idx) ? 10'd1023 : 10'(v.r);
      send_beat(r, 10'(v.g), 10'(v.b), i == 0, eol, gap, bp);
      if (i + 1 == v.short_at) break;
    end
    idle(3);
    check($sformatf("v%0d_valid_pulses", id), n_valid, v.exp_valid);
    check($sformatf("v%0d_err_pulses", id), n_err, v.exp_err);
    check($sformatf("v%0d_r", id), st_r, v.er);
    check($sformatf("v%0d_g", id), st_g, v.eg);
    check($sformatf("v%0d_b", id), st_b, v.eb);
    check($sformatf("v%0d_cnt", id), st_cnt, v.ec);
  endtask

  function automatic logic [9:0] rnd_px();
    return ($urandom_range(9) == 0) ? 10'd1023 : 10'($urandom_range(1022));
  endfunction

  initial begin
    vec_t tbl[6];
    tbl[0] = '{100, 200, 300, 0, -1, 1, 0, 800, 1600, 2400, 8};
    tbl[1] = '{10, 10, 10, 3, -1, 0, 1, 800, 1600, 2400, 8};
    tbl[2] = '{10, 10, 10, 0, -1, 1, 0, 80, 80, 80, 8};
`ifdef WB_STAT_SAT_EXCL_EN
    tbl[3] = '{10, 10, 10, 0, 5, 1, 0, 70, 70, 70, 7};
    tbl[4] = '{1023, 1023, 1023, 0, -1, 1, 0, 0, 0, 0, 0};
`else
    tbl[3] = '{10, 10, 10, 0, 5, 1, 0, 1093, 80, 80, 8};
    tbl[4] = '{1023, 1023, 1023, 0, -1, 1, 0, 8184, 8184, 8184, 8};
`endif
    tbl[5] = '{0, 0, 0, 0, -1, 1, 0, 0, 0, 0, 8};

    repeat (3) @(posedge clk);
    #1;
    check("reset_r", st_r, 0);
    check("reset_g", st_g, 0);
    check("reset_b", st_b, 0);
    check("reset_cnt", st_cnt, 0);
    check("reset_valid", st_valid, 0);
    rst_n = 1'b1;
    idle(2);

    for (int i = 0; i < 6; i++) run_vec(i, tbl[i], 0, 0);

    // Same flat frame under random gaps and backpressure.
    run_vec(10, tbl[0], 40, 50);

    // SOF in the middle of a frame restarts accumulation.
    n_valid = 0; n_err = 0;
    for (int i = 0; i < 3; i++) send_beat(10'd50, 10'd50, 10'd50, i == 0, 1'b0, 0, 0);
    for (int i = 0; i < X * Y; i++) send_beat(10'd10, 10'd10, 10'd10, i == 0, (i % X) == X - 1, 0, 0);
    idle(3);
    check("restart_err", n_err, 1);
    check("restart_valid", n_valid, 1);
    check("restart_r", st_r, 80);
    check("restart_cnt", st_cnt, 8);

    // Line overrun: five beats without tlast.
    n_valid = 0; n_err = 0;
    for (int i = 0; i < X + 1; i++) send_beat(10'd7, 10'd7, 10'd7, i == 0, 1'b0, 0, 0);
    idle(3);
    check("overrun_err", n_err, 1);
    check("overrun_valid", n_valid, 0);
    check("overrun_r_held", st_r, 80);

    // SOF and EOL on one beat: a one-pixel line is malformed.
    n_err = 0;
    send_beat(10'd1, 10'd1, 10'd1, 1'b1, 1'b1, 0, 0);
    idle(3);
    check("sof_eol_err", n_err, 1);

    // Asynchronous reset mid-frame, then a frame lacking SOF is ignored.
    for (int i = 0; i < 3; i++) send_beat(10'd5, 10'd5, 10'd5, i == 0, 1'b0, 0, 0);
    rst_n = 1'b0;
    #1;
    check("arst_r", st_r, 0);
    check("arst_g", st_g, 0);
    check("arst_b", st_b, 0);
    check("arst_cnt", st_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_valid = 0; n_err = 0;
    for (int i = 0; i < X * Y; i++) send_beat(10'd9, 10'd9, 10'd9, 1'b0, (i % X) == X - 1, 0, 0);
    idle(3);
    check("nosof_valid", n_valid, 0);
    check("nosof_err", n_err, 0);
    check("nosof_r", st_r, 0);
    run_vec(20, tbl[2], 0, 0);

    // Random stream with injected framing faults, checked against the model every cycle.
    for (int f = 0; f < 40; f++) begin
      int kind, cut;
      kind = $urandom_range(5);
      cut = $urandom_range(X * Y - 1);
      for (int i = 0; i < X * Y; i++) begin
        bit eol;
        eol = (i % X) == X - 1;
        if (kind == 0 && i == cut) eol = 1'b1;
        if (kind == 1 && i == cut) eol = 1'b0;
        send_beat(rnd_px(), rnd_px(), rnd_px(), i == 0, eol, 30, 30);
        if (kind == 2 && i == cut) break;
      end
    end
    idle(3);
    run_vec(30, tbl[0], 20, 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
